// File: rtl/mt_thread_sched.sv
// mt_thread_sched: round-robin thread scheduler and per-thread PC bank for
// the barrel RISC-V core. Each cycle it issues the next eligible thread's ID
// and PC. A per-thread cooldown keeps at most one instruction per thread in
// flight. Optional idle-cycle counter enabled with `define MT_SCHED_PERF_EN.
module mt_thread_sched #(
    parameter int                    NUM_THREADS      = 8,
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    PIPE_DEPTH       = 5,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0,
    parameter logic [ADDR_WIDTH-1:0] THREAD_PC_OFFSET = ADDR_WIDTH'(32'h0000_1000)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_THREADS-1:0]         run_mask,
    input  logic                           stall,
    input  logic                           redirect_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] redirect_tid,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc,
    input  logic                           halt_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] halt_tid,
    output logic                           issue_valid,
    output logic [$clog2(NUM_THREADS)-1:0] issue_tid,
    output logic [ADDR_WIDTH-1:0]          issue_pc,
    output logic [NUM_THREADS-1:0]         active_mask,
    output logic [31:0]                    bubble_count
);

    localparam int TW = $clog2(NUM_THREADS);
    localparam int CW = $clog2(PIPE_DEPTH + 1);
    localparam logic [CW-1:0] COOL_INIT = CW'(PIPE_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] pc [NUM_THREADS];
    logic [CW-1:0]         cool [NUM_THREADS];
    logic [TW-1:0]         last_tid;
    logic [NUM_THREADS-1:0] eligible;
    logic [TW-1:0]         sel;
    logic [TW-1:0]         scan_idx;
    logic                  found;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic                  redirect_hits_sel;
    logic [ADDR_WIDTH-1:0] next_issue_pc;

    assign redirect_aligned  = redirect_pc & ~ADDR_WIDTH'(3);
    assign redirect_hits_sel = redirect_valid && (redirect_tid == sel);
    assign next_issue_pc     = redirect_hits_sel ? redirect_aligned : pc[sel];

    // A thread may issue when alive, permitted, cooled down and not being halted now
    always_comb begin
        eligible = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            eligible[t] = active_mask[t] && run_mask[t] && (cool[t] == '0) &&
                          !(halt_valid && (halt_tid == TW'(t)));
        end
    end

    // Round-robin pick: scan backwards so the thread just after last_tid wins, last_tid checked last
    always_comb begin
        sel      = last_tid;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = NUM_THREADS; i >= 1; i--) begin
            scan_idx = last_tid + TW'(i);
            if (eligible[scan_idx]) begin
                sel   = scan_idx;
                found = 1'b1;
            end
        end
    end

    // Issue registers, round-robin pointer and cooldowns; all frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_tid   <= '0;
            issue_pc    <= '0;
            last_tid    <= TW'(NUM_THREADS - 1);
            for (int t = 0; t < NUM_THREADS; t++) cool[t] <= '0;
        end else if (!stall) begin
            issue_valid <= found;
            if (found) begin
                issue_tid <= sel;
                issue_pc  <= next_issue_pc;
                last_tid  <= sel;
            end
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (found && (sel == TW'(t))) cool[t] <= COOL_INIT;
                else if (cool[t] != '0)       cool[t] <= cool[t] - 1'b1;
            end
        end
    end

    // PC bank: halt beats redirect, redirect applies even under stall, issue advances by 4
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++)
                pc[t] <= RESET_PC + ADDR_WIDTH'(t) * THREAD_PC_OFFSET;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (halt_valid && (halt_tid == TW'(t))) begin
                    pc[t] <= pc[t];
                end else if (redirect_valid && (redirect_tid == TW'(t))) begin
                    if (!stall && found && (sel == TW'(t)))
                        pc[t] <= redirect_aligned + ADDR_WIDTH'(4);
                    else
                        pc[t] <= redirect_aligned;
                end else if (!stall && found && (sel == TW'(t))) begin
                    pc[t] <= pc[t] + ADDR_WIDTH'(4);
                end
            end
        end
    end

    // Thread liveness: halts clear a bit permanently until reset, regardless of stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mask <= '1;
        end else if (halt_valid) begin
            active_mask[halt_tid] <= 1'b0;
        end
    end

`ifdef MT_SCHED_PERF_EN
    // Saturating count of non-stalled cycles that produced no issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (!stall && !found && (bubble_count != 32'hFFFF_FFFF)) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_mt_thread_sched.sv
// tb_mt_thread_sched: directed self-checking bench for mt_thread_sched with
// default parameters (8 threads, PIPE_DEPTH 5, 0x1000 per-thread PC offset).
module tb_mt_thread_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  run_mask;
    logic        stall;
    logic        redirect_valid;
    logic [2:0]  redirect_tid;
    logic [31:0] redirect_pc;
    logic        halt_valid;
    logic [2:0]  halt_tid;
    logic        issue_valid;
    logic [2:0]  issue_tid;
    logic [31:0] issue_pc;
    logic [7:0]  active_mask;
    logic [31:0] bubble_count;

    int errors = 0;
    int checks = 0;

    int exp_tid_d [13] = '{0, 1, 2, 3, 4, 6, 7, 0, 1, 2, 3, 4, 6};

    mt_thread_sched dut (
        .clk            (clk),
        .rst            (rst),
        .run_mask       (run_mask),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .issue_valid    (issue_valid),
        .issue_tid      (issue_tid),
        .issue_pc       (issue_pc),
        .active_mask    (active_mask),
        .bubble_count   (bubble_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] rm, input logic st,
                                 input logic rv, input logic [2:0] rt, input logic [31:0] rp,
                                 input logic hv, input logic [2:0] ht);
        run_mask       = rm;
        stall          = st;
        redirect_valid = rv;
        redirect_tid   = rt;
        redirect_pc    = rp;
        halt_valid     = hv;
        halt_tid       = ht;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIssue(input string tag, input logic v, input int tid, input logic [31:0] pcv);
        checkOutput({tag, ".valid"}, {31'd0, issue_valid}, {31'd0, v});
        checkOutput({tag, ".tid"}, {29'd0, issue_tid}, 32'(tid));
        checkOutput({tag, ".pc"}, issue_pc, pcv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_bubble;
`ifdef MT_SCHED_PERF_EN
        exp_bubble = 32'd8;
`else
        exp_bubble = 32'd0;
`endif
        $display("[TB] start");

        // Reset values
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        #12;
        checkIssue("reset", 1'b0, 0, 32'h0);
        checkOutput("reset.active", {24'd0, active_mask}, 32'h0000_00FF);
        checkOutput("reset.bubble", bubble_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All threads running: 0..7 then thread 0 again at PC 4
        applyStimulus(8'hFF, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            checkIssue($sformatf("rr%0d", i), 1'b1, i % 8, (i < 8) ? 32'(i) * 32'h1000 : 32'h4);
        end

        // Single thread: one issue every PIPE_DEPTH cycles
        doReset();
        applyStimulus(8'h04, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        for (int c = 1; c <= 11; c++) begin
            tick();
            checkOutput($sformatf("single.valid%0d", c), {31'd0, issue_valid},
                        {31'd0, (c == 1 || c == 6 || c == 11)});
            if (c == 1)  checkIssue("single.first", 1'b1, 2, 32'h2000);
            if (c == 2)  checkIssue("single.hold", 1'b0, 2, 32'h2000);
            if (c == 6)  checkIssue("single.second", 1'b1, 2, 32'h2004);
            if (c == 11) checkIssue("single.third", 1'b1, 2, 32'h2008);
        end
        checkOutput("single.bubble", bubble_count, exp_bubble);

        // Redirect thread 3 during cooldown, then in its own selection cycle
        doReset();
        applyStimulus(8'hFF, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        for (int c = 1; c <= 36; c++) begin
            applyStimulus(8'hFF, 1'b0, (c == 5 || c == 28), 3'd3, 32'h0000_0103, 1'b0, 3'd0);
            tick();
            if (c == 4)  checkIssue("redir.pre", 1'b1, 3, 32'h3000);
            if (c == 5)  checkIssue("redir.other", 1'b1, 4, 32'h4000);
            if (c == 12) checkIssue("redir.first", 1'b1, 3, 32'h100);
            if (c == 20) checkIssue("redir.next", 1'b1, 3, 32'h104);
            if (c == 28) checkIssue("redir.bypass", 1'b1, 3, 32'h100);
            if (c == 36) checkIssue("redir.after", 1'b1, 3, 32'h104);
        end

        // Halt thread 5 in its selection cycle with a same-cycle redirect
        doReset();
        applyStimulus(8'hFF, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        for (int c = 1; c <= 13; c++) begin
            applyStimulus(8'hFF, 1'b0, (c == 6), 3'd5, 32'h500, (c == 6), 3'd5);
            tick();
            checkOutput($sformatf("halt.tid%0d", c), {29'd0, issue_tid}, 32'(exp_tid_d[c-1]));
            if (c == 6)  checkOutput("halt.pc6", issue_pc, 32'h6000);
            if (c == 8)  checkOutput("halt.pc8", issue_pc, 32'h4);
            if (c == 13) checkOutput("halt.pc13", issue_pc, 32'h6004);
        end
        checkOutput("halt.active", {24'd0, active_mask}, 32'h0000_00DF);

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        checkIssue("async", 1'b0, 0, 32'h0);
        checkOutput("async.active", {24'd0, active_mask}, 32'h0000_00FF);
        checkOutput("async.bubble", bubble_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkIssue("async.restart", 1'b1, 0, 32'h0);

        // Stall three cycles with a redirect of thread 4 in the middle
        doReset();
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(8'hFF, (c >= 4 && c <= 6), (c == 5), 3'd4, 32'h404, 1'b0, 3'd0);
            tick();
            if (c == 3)             checkIssue("stall.pre", 1'b1, 2, 32'h2000);
            if (c >= 4 && c <= 6)   checkIssue($sformatf("stall.hold%0d", c), 1'b1, 2, 32'h2000);
            if (c == 7)             checkIssue("stall.resume", 1'b1, 3, 32'h3000);
            if (c == 8)             checkIssue("stall.redir", 1'b1, 4, 32'h404);
            if (c == 9)             checkIssue("stall.next", 1'b1, 5, 32'h5000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
